ap_s: RTL and testbench
=======================

# ap_s

Associative-processor core holding three CAM columns (A, B, C), each split into two internal sub-columns of CELL_QUANT words. The host loads operands word-by-word, triggers a column-parallel operation C = A op B, polls a completion flag, then reads results back. It sits behind the memory-mapped register/address decoder of the AP peripheral, which drives all inputs from bus requests.

## Interface
Parameters:
- WORD_SIZE, 8, bits per stored word.
- CELL_QUANT, 128, rows per sub-column; must be a power of two. RB = log2(CELL_QUANT); AW = RB+1.

Ports:
- clock  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr_in  in  AW  row address; only addr_in[RB-1:0] is used, upper bit ignored.
- data_in  in  WORD_SIZE  write data.
- write_en  in  1  host write strobe.
- read_en  in  1  host read strobe.
- sel_col  in  2  column select for host access: 0=A, 1=B, 2=C, 3=none.
- sel_internal_col  in  1  sub-column select (host access and compute).
- op_direction  in  1  0=vertical (bit-serial), 1=horizontal (word-serial).
- cmd  in  3  operation code.
- ap_mode  in  1  compute trigger level.
- data_out  out  WORD_SIZE  registered read data.
- ap_state_irq  out  1  computation-complete flag.

## Operation
- Storage: mem[col 0..2][sub 0..1][row 0..CELL_QUANT-1], WORD_SIZE bits each.
- FSM states: IDLE, BUSY, DONE.
- IDLE + ap_mode=1 at an edge: latch cmd, op_direction, sel_internal_col (S); clear counter; set per-row carry; go BUSY.
- Commands (C[S][r] = f(A[S][r], B[S][r]), all results mod 2^WORD_SIZE): 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 XOR; 5 NOT A (B ignored); 6,7 reserved: run full sequence, C unchanged.
- Vertical (op_direction=0): one bit position k per BUSY cycle, k=0..WORD_SIZE−1 (LSB first), all rows in parallel. ADD: C bit = A^B^carry_r, carry_r = majority(A,B,carry_r), carry init 0. SUB: same with ~B and carry init 1. Logic ops bitwise on bit k.
- Horizontal (op_direction=1): one row r per BUSY cycle, r=0..CELL_QUANT−1, full-word result written to C[S][r].
- BUSY at last index (k=WORD_SIZE−1 or r=CELL_QUANT−1): complete that step, go DONE.
- DONE: ap_state_irq=1; stays DONE while ap_mode=1. ap_mode=0 in DONE → IDLE, irq=0 (no auto-restart while level held).
- ap_mode dropped during BUSY: ignored; operation completes, then DONE → IDLE on next edge since ap_mode=0 (irq pulses one cycle).
- Host write (IDLE or DONE only): write_en=1, sel_col∈{0,1,2} → mem[sel_col][sel_internal_col][row] <= data_in. sel_col=3: no write. Ignored in BUSY.
- Host read (IDLE or DONE): read_en=1 and write_en=0 → data_out <= addressed word (sel_col=3 → 0). Otherwise data_out holds. Reads in BUSY ignored.

## Timing
- rst low (async): FSM=IDLE, data_out=0, ap_state_irq=0, all carries=0, all memory words=0. Reset mid-BUSY aborts the operation.
- Write: stored at the write_en edge; readable by a read issued the next cycle.
- Read latency: 1 cycle (data_out valid after the edge sampling read_en).
- Compute: edge 0 samples ap_mode → BUSY; edges 1..N process (N=WORD_SIZE vertical, CELL_QUANT horizontal); ap_state_irq high after edge N, i.e. N+1 edges after trigger.
- ap_state_irq is registered; low in IDLE and BUSY.
- Simultaneous write_en and read_en: write happens, data_out holds.

## Test plan
- Reset: drive rst=0 mid-operation → data_out=0, irq=0; read A[0][5] afterwards → 0.
- Write/read: write 0x5A to A sub0 row 3, 0xC3 to B sub1 row 127; read back → 0x5A, 0xC3 one cycle after read_en; sel_col=3 read → 0x00.
- Vertical ADD: A[0][r]=r, B[0][r]=200 for all rows, cmd=0, op_direction=0, ap_mode=1 → irq rises 9 edges later; C[0][r]=(r+200) mod 256 (row 100 → 0x2C); sub1 of C unchanged.
- Horizontal SUB: A[1][r]=10, B[1][r]=r, cmd=1, op_direction=1, sub1 → irq after 129 edges; C[1][20]=0xF6, C[1][10]=0x00.
- Logic/reserved: A=0xF0, B=0x3C; cmd 2/3/4/5 → 0x30/0xFC/0xCC/0x0F; cmd 6 → C unchanged, irq still asserted.
- Handshake: hold ap_mode=1 after DONE → irq stays 1, no rerun (C untouched after A rewritten in DONE); ap_mode=0 → irq 0 next edge; writes during BUSY do not modify memory.

Source files
------------

// File: rtl/ap_s_if.sv
`default_nettype none
// ==================================================================
// Module : ap_s_if
// Host-side bus bundle of the associative processor core.
// Rev    : 1.0
// ==================================================================
interface ap_s_if #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 128
);
  localparam int C_AW = $clog2(CELL_QUANT) + 1;

  logic [C_AW-1:0]      addr_in;
  logic [WORD_SIZE-1:0] data_in;
  logic                 write_en;
  logic                 read_en;
  logic [1:0]           sel_col;
  logic                 sel_internal_col;
  logic                 op_direction;
  logic [2:0]           cmd;
  logic                 ap_mode;
  logic [WORD_SIZE-1:0] data_out;
  logic                 ap_state_irq;

  modport master (
    output addr_in, data_in, write_en, read_en, sel_col, sel_internal_col,
           op_direction, cmd, ap_mode,
    input  data_out, ap_state_irq
  );

  modport slave (
    input  addr_in, data_in, write_en, read_en, sel_col, sel_internal_col,
           op_direction, cmd, ap_mode,
    output data_out, ap_state_irq
  );
endinterface
`default_nettype wire

// File: rtl/ap_s.sv
`default_nettype none
// ==================================================================
// Module : ap_s
// Associative-processor core: three CAM columns, C = A op B computed
// bit-serially (all rows at once) or word-serially (one row per cycle).
// Rev    : 1.0
// ==================================================================
module ap_s #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 128
) (
  input  logic  clock,
  input  logic  rst,
  ap_s_if.slave bus
);
  localparam int C_RB = $clog2(CELL_QUANT);
  localparam int C_KB = $clog2(WORD_SIZE);
  localparam int C_CW = (C_RB > C_KB) ? C_RB : C_KB;

  localparam logic [2:0] C_CMD_ADD = 3'd0;
  localparam logic [2:0] C_CMD_SUB = 3'd1;
  localparam logic [2:0] C_CMD_AND = 3'd2;
  localparam logic [2:0] C_CMD_OR  = 3'd3;
  localparam logic [2:0] C_CMD_XOR = 3'd4;
  localparam logic [2:0] C_CMD_NOT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [C_CW-1:0]       r_cnt;
  logic [2:0]            r_cmd;
  logic                  r_dir;
  logic                  r_sub;
  logic                  r_irq;
  logic [WORD_SIZE-1:0]  r_data_out;
  logic [CELL_QUANT-1:0] r_carry;
  logic [WORD_SIZE-1:0]  r_mem [3][2][CELL_QUANT];

  logic                  w_start;
  logic                  w_last;
  logic                  w_busy;
  logic [C_RB-1:0]       w_row;
  logic [C_RB-1:0]       w_hrow;
  logic [C_KB-1:0]       w_bit;
  logic [WORD_SIZE-1:0]  w_hword;
  logic [CELL_QUANT-1:0] w_vbit;
  logic [CELL_QUANT-1:0] w_vcarry;

  function automatic logic [WORD_SIZE-1:0] f_word(
    input logic [2:0]           op,
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b
  );
    case (op)
      C_CMD_ADD: f_word = a + b;
      C_CMD_SUB: f_word = a - b;
      C_CMD_AND: f_word = a & b;
      C_CMD_OR:  f_word = a | b;
      C_CMD_XOR: f_word = a ^ b;
      C_CMD_NOT: f_word = ~a;
      default:   f_word = '0;
    endcase
  endfunction

  // For SUB the caller already inverted b; the sum term is shared with ADD.
  function automatic logic f_bit(
    input logic [2:0] op,
    input logic       a,
    input logic       b,
    input logic       cin
  );
    case (op)
      C_CMD_ADD, C_CMD_SUB: f_bit = a ^ b ^ cin;
      C_CMD_AND:            f_bit = a & b;
      C_CMD_OR:             f_bit = a | b;
      C_CMD_XOR:            f_bit = a ^ b;
      C_CMD_NOT:            f_bit = ~a;
      default:              f_bit = 1'b0;
    endcase
  endfunction

  assign w_busy  = (r_state == S_BUSY);
  assign w_start = (r_state == S_IDLE) && bus.ap_mode;
  assign w_row   = bus.addr_in[C_RB-1:0];
  assign w_hrow  = r_cnt[C_RB-1:0];
  assign w_bit   = r_cnt[C_KB-1:0];
  assign w_last  = r_dir ? (r_cnt == C_CW'(CELL_QUANT - 1))
                         : (r_cnt == C_CW'(WORD_SIZE - 1));
  assign w_hword = f_word(r_cmd, r_mem[0][r_sub][w_hrow], r_mem[1][r_sub][w_hrow]);

  for (genvar gi = 0; gi < CELL_QUANT; gi++) begin : g_row
    logic w_a;
    logic w_b;
    assign w_a = r_mem[0][r_sub][gi][w_bit];
    assign w_b = (r_cmd == C_CMD_SUB) ? ~r_mem[1][r_sub][gi][w_bit]
                                      :  r_mem[1][r_sub][gi][w_bit];
    assign w_vbit[gi]   = f_bit(r_cmd, w_a, w_b, r_carry[gi]);
    assign w_vcarry[gi] = (w_a & w_b) | (w_a & r_carry[gi]) | (w_b & r_carry[gi]);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DONE is held as long as the trigger level stays high.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.ap_mode) w_state_next = S_BUSY;
      S_BUSY:  if (w_last)      w_state_next = S_DONE;
      S_DONE:  if (!bus.ap_mode) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_irq <= 1'b0;
      r_cnt <= '0;
      r_cmd <= '0;
      r_dir <= 1'b0;
      r_sub <= 1'b0;
    end else begin
      r_irq <= (w_state_next == S_DONE);
      if (w_start) begin
        r_cmd <= bus.cmd;
        r_dir <= bus.op_direction;
        r_sub <= bus.sel_internal_col;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + C_CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_carry <= '0;
    end else if (w_start) begin
      r_carry <= {CELL_QUANT{bus.cmd == C_CMD_SUB}};
    end else if (w_busy && !r_dir) begin
      r_carry <= w_vcarry;
    end
  end

  // Host writes are locked out while the array is computing.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int s = 0; s < 2; s++) begin
          for (int r = 0; r < CELL_QUANT; r++) begin
            r_mem[c][s][r] <= '0;
          end
        end
      end
    end else if (w_busy) begin
      if (r_cmd <= C_CMD_NOT) begin
        if (r_dir) begin
          r_mem[2][r_sub][w_hrow] <= w_hword;
        end else begin
          for (int r = 0; r < CELL_QUANT; r++) begin
            r_mem[2][r_sub][r][w_bit] <= w_vbit[r];
          end
        end
      end
    end else if (bus.write_en && (bus.sel_col != 2'd3)) begin
      r_mem[bus.sel_col][bus.sel_internal_col][w_row] <= bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
    end else if (!w_busy && bus.read_en && !bus.write_en) begin
      if (bus.sel_col == 2'd3) begin
        r_data_out <= '0;
      end else begin
        r_data_out <= r_mem[bus.sel_col][bus.sel_internal_col][w_row];
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.ap_state_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ap_s.sv
`default_nettype none
// ==================================================================
// Module : tb_ap_s
// Self-checking bench for ap_s against an array-level reference model.
// Rev    : 1.0
// ==================================================================
module tb_ap_s;
  localparam int WS = 8;
  localparam int CQ = 128;
  localparam int RB = 7;
  localparam int AW = 8;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  ap_s_if #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) bus ();
  ap_s #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] ref_mem [3][2][CQ];
  logic [7:0] logic_lut [8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int row);
    bus.addr_in = AW'(row) | (AW'($urandom_range(0, 1)) << RB);
  endtask

  task automatic wr(input int col, input int sub, input int row, input logic [7:0] d);
    bus.sel_col          = 2'(col);
    bus.sel_internal_col = sub[0];
    set_addr(row);
    bus.data_in  = d;
    bus.write_en = 1'b1;
    step();
    bus.write_en = 1'b0;
    if (col < 3) ref_mem[col][sub][row] = d;
  endtask

  task automatic rd(input string tag, input int col, input int sub, input int row);
    logic [7:0] e;
    e = 8'h00;
    if (col < 3) e = ref_mem[col][sub][row];
    bus.sel_col          = 2'(col);
    bus.sel_internal_col = sub[0];
    set_addr(row);
    bus.read_en = 1'b1;
    step();
    bus.read_en = 1'b0;
    check(tag, 32'(bus.data_out), 32'(e));
  endtask

  task automatic check_col(input string tag, input int col, input int sub);
    for (int r = 0; r < CQ; r++) rd(tag, col, sub, r);
  endtask

  // Reference: whole-word arithmetic on every row of the selected sub-column.
  task automatic model_op(input int c, input int s);
    logic [7:0] a, b;
    for (int r = 0; r < CQ; r++) begin
      a = ref_mem[0][s][r];
      b = ref_mem[1][s][r];
      case (c)
        0: ref_mem[2][s][r] = a + b;
        1: ref_mem[2][s][r] = a - b;
        2: ref_mem[2][s][r] = a & b;
        3: ref_mem[2][s][r] = a | b;
        4: ref_mem[2][s][r] = a ^ b;
        5: ref_mem[2][s][r] = ~a;
        default: ;
      endcase
    end
  endtask

  // Leaves ap_mode high with the core sitting in DONE.
  task automatic run_op(input string tag, input int c, input int d, input int s);
    int n, edges;
    n = (d != 0) ? CQ : WS;
    bus.write_en         = 1'b0;
    bus.read_en          = 1'b0;
    bus.cmd              = c[2:0];
    bus.op_direction     = d[0];
    bus.sel_internal_col = s[0];
    bus.ap_mode          = 1'b1;
    step();
    edges = 1;
    check({tag, "_busy_irq"}, 32'(bus.ap_state_irq), 32'd0);
    while (bus.ap_state_irq !== 1'b1 && edges < n + 20) begin
      step();
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(n + 1));
    model_op(c, s);
  endtask

  task automatic release_op(input string tag);
    bus.ap_mode = 1'b0;
    step();
    check({tag, "_irq_clear"}, 32'(bus.ap_state_irq), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c, d, edges;
    logic [7:0] v;

    bus.addr_in = '0; bus.data_in = '0; bus.write_en = 1'b0; bus.read_en = 1'b0;
    bus.sel_col = 2'd3; bus.sel_internal_col = 1'b0; bus.op_direction = 1'b0;
    bus.cmd = 3'd0; bus.ap_mode = 1'b0;
    for (int cc = 0; cc < 3; cc++)
      for (int ss = 0; ss < 2; ss++)
        for (int r = 0; r < CQ; r++) ref_mem[cc][ss][r] = 8'h00;
    logic_lut[2] = 8'h30; logic_lut[3] = 8'hFC; logic_lut[4] = 8'hCC; logic_lut[5] = 8'h0F;

    // Reset state
    repeat (3) @(posedge clock);
    #1 rst = 1'b1;
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_irq", 32'(bus.ap_state_irq), 32'd0);
    rd("rst_mem_a05", 0, 0, 5);

    // Basic write/read, unselected column reads zero
    wr(0, 0, 3, 8'h5A);
    wr(1, 1, 127, 8'hC3);
    rd("rd_a0_r3", 0, 0, 3);
    check("rd_a0_r3_const", 32'(bus.data_out), 32'h5A);
    rd("rd_b1_r127", 1, 1, 127);
    check("rd_b1_r127_const", 32'(bus.data_out), 32'hC3);
    rd("rd_none", 3, 0, 3);

    // Simultaneous write and read: write lands, data_out holds
    rd("rd_hold_pre", 0, 0, 3);
    bus.sel_col = 2'd1; bus.sel_internal_col = 1'b0; set_addr(4);
    bus.data_in = 8'h77; bus.write_en = 1'b1; bus.read_en = 1'b1;
    step();
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    ref_mem[1][0][4] = 8'h77;
    check("wr_rd_hold", 32'(bus.data_out), 32'h5A);
    rd("wr_rd_stored", 1, 0, 4);

    // Vertical ADD on sub 0; sub 1 of C must be untouched
    for (int r = 0; r < CQ; r++) begin
      wr(0, 0, r, 8'(r));
      wr(1, 0, r, 8'd200);
      wr(2, 1, r, 8'($urandom));
    end
    run_op("vadd", 0, 0, 0);
    release_op("vadd");
    check_col("vadd_c0", 2, 0);
    check_col("vadd_c1_keep", 2, 1);
    rd("vadd_r100", 2, 0, 100);
    check("vadd_r100_const", 32'(bus.data_out), 32'h2C);

    // Horizontal SUB on sub 1
    for (int r = 0; r < CQ; r++) begin
      wr(0, 1, r, 8'd10);
      wr(1, 1, r, 8'(r));
    end
    run_op("hsub", 1, 1, 1);
    release_op("hsub");
    check_col("hsub_c1", 2, 1);
    rd("hsub_r20", 2, 1, 20);
    check("hsub_r20_const", 32'(bus.data_out), 32'hF6);
    rd("hsub_r10", 2, 1, 10);
    check("hsub_r10_const", 32'(bus.data_out), 32'h00);

    // Logic and reserved commands, random direction
    for (int r = 0; r < CQ; r++) begin
      wr(0, 0, r, 8'($urandom));
      wr(1, 0, r, 8'($urandom));
    end
    wr(0, 0, 7, 8'hF0);
    wr(1, 0, 7, 8'h3C);
    for (int op = 2; op < 8; op++) begin
      d = int'($urandom_range(0, 1));
      run_op($sformatf("logic%0d", op), op, d, 0);
      release_op($sformatf("logic%0d", op));
      check_col($sformatf("logic%0d_c0", op), 2, 0);
      if (op <= 5) begin
        rd($sformatf("logic%0d_r7", op), 2, 0, 7);
        check($sformatf("logic%0d_r7_const", op), 32'(bus.data_out), 32'(logic_lut[op]));
      end
    end

    // Random operations
    repeat (4) begin
      s = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 1));
      for (int r = 0; r < CQ; r++) begin
        wr(0, s, r, 8'($urandom));
        wr(1, s, r, 8'($urandom));
      end
      run_op($sformatf("rand_c%0d_d%0d_s%0d", c, d, s), c, d, s);
      release_op("rand");
      check_col($sformatf("rand_c%0d_d%0d_s%0d", c, d, s), 2, s);
    end

    // Level held in DONE: irq stays, no rerun after operand rewrite
    run_op("hold", 0, 0, 0);
    v = ref_mem[0][0][0] ^ 8'hFF;
    wr(0, 0, 0, v);
    repeat (20) step();
    check("hold_irq", 32'(bus.ap_state_irq), 32'd1);
    release_op("hold");
    rd("hold_no_rerun", 2, 0, 0);
    rd("hold_a_written", 0, 0, 0);

    // ap_mode dropped during BUSY, host writes during BUSY ignored
    bus.cmd = 3'd0; bus.op_direction = 1'b0; bus.sel_internal_col = 1'b0;
    bus.ap_mode = 1'b1;
    step();
    edges = 1;
    bus.ap_mode = 1'b0;
    check("drop_busy_irq", 32'(bus.ap_state_irq), 32'd0);
    bus.sel_col = 2'd0; bus.sel_internal_col = 1'b0; set_addr(0);
    bus.data_in = ~ref_mem[0][0][0]; bus.write_en = 1'b1;
    step(); edges++;
    bus.sel_col = 2'd1; bus.sel_internal_col = 1'b1; set_addr(9);
    bus.data_in = ~ref_mem[1][1][9];
    step(); edges++;
    bus.write_en = 1'b0;
    while (bus.ap_state_irq !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
    check("drop_latency", 32'(edges), 32'(WS + 1));
    step();
    check("drop_irq_pulse", 32'(bus.ap_state_irq), 32'd0);
    model_op(0, 0);
    check_col("drop_c0", 2, 0);
    rd("busy_wr_a0", 0, 0, 0);
    rd("busy_wr_b1", 1, 1, 9);

    // Asynchronous reset in the middle of a horizontal run
    rd("pre_rst_read", 0, 0, 7);
    bus.cmd = 3'd4; bus.op_direction = 1'b1; bus.sel_internal_col = 1'b1;
    bus.ap_mode = 1'b1;
    step();
    repeat (10) step();
    #3 rst = 1'b0;
    #1;
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_irq", 32'(bus.ap_state_irq), 32'd0);
    bus.ap_mode = 1'b0;
    for (int cc = 0; cc < 3; cc++)
      for (int ss = 0; ss < 2; ss++)
        for (int r = 0; r < CQ; r++) ref_mem[cc][ss][r] = 8'h00;
    @(posedge clock);
    #1 rst = 1'b1;
    rd("midrst_a05", 0, 0, 5);
    rd("midrst_a07", 0, 0, 7);
    rd("midrst_c1_20", 2, 1, 20);
    rd("midrst_b1_127", 1, 1, 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
